// File: rtl/capture_gray_frontend_if.sv
// ---------------------------------------------------------------------------
// capture_gray_frontend_if
// Bundles the camera stream, grayscale output and grayscale-memory handshake
// of one camera channel front end.
//   start, clear       : frame start request / capture RAM pointer clear
//   cam_valid/cam_data : camera byte stream (R,G,B per pixel)
//   camera_enable      : camera streaming enable
//   gs_valid/gs_data   : grayscale pixel stream
//   rwm2_enable/rw_2   : grayscale memory enable / direction (1 = write)
//   rwm2_done          : grayscale memory operation-complete pulse
//   frame_done         : end-of-readout pulse
// slave  : the front end itself
// master : the surrounding system (camera, memory, sequencer)
// ---------------------------------------------------------------------------
interface capture_gray_frontend_if;
    logic       start;
    logic       clear;
    logic       cam_valid;
    logic [7:0] cam_data;
    logic       rwm2_done;
    logic       camera_enable;
    logic [7:0] gs_data;
    logic       gs_valid;
    logic       rwm2_enable;
    logic       rw_2;
    logic       frame_done;

    modport slave (
        input  start, clear, cam_valid, cam_data, rwm2_done,
        output camera_enable, gs_data, gs_valid, rwm2_enable, rw_2, frame_done
    );

    modport master (
        output start, clear, cam_valid, cam_data, rwm2_done,
        input  camera_enable, gs_data, gs_valid, rwm2_enable, rw_2, frame_done
    );
endinterface

// File: rtl/capture_gray_frontend.sv
// ---------------------------------------------------------------------------
// capture_gray_frontend
// Captures one RGB frame into a byte-wide capture RAM, replays it through an
// RGB-to-gray converter into the external grayscale memory, then commands
// that memory to read out.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : capture_gray_frontend_if.slave (camera, gray stream, memory
//             handshake, start/clear, frame_done)
// ---------------------------------------------------------------------------
module capture_gray_frontend #(
    parameter int PIXELS = 64,
    parameter int DEPTH  = 3 * PIXELS
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    capture_gray_frontend_if.slave        bus
);
    localparam int AW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(PIXELS + 1);
    localparam logic [AW-1:0] PTR_END  = AW'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] PIX_LAST = CW'(PIXELS - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, CONVERT, READOUT} state_t;

    state_t        r_state;
    logic          r_camera_enable;
    logic          r_rwm2_enable;
    logic          r_rw_2;
    logic          r_frame_done;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic          r_wr_done;
    logic [7:0]    r_rd_data;
    logic          r_rd_valid;

    logic [1:0]    r_byte_cnt;
    logic [7:0]    r_red;
    logic [7:0]    r_grn;
    logic [7:0]    r_gs_data;
    logic          r_gs_valid;
    logic [CW-1:0] r_gs_cnt;
    logic          r_gs_done;

    logic          w_new_frame;
    logic          w_leave_convert;
    logic          w_pause;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [15:0]   w_sum;

    // A frame starts only from IDLE; start is ignored everywhere else.
    assign w_new_frame     = (r_state == IDLE) && bus.start;
    // rwm2_done during CONVERT counts only once every pixel has been issued.
    assign w_leave_convert = (r_state == CONVERT) && bus.rwm2_done && r_gs_done;
    // Stall the RAM read for the cycle in which the B byte is being consumed,
    // which leaves one bubble per pixel (4-cycle pixel period).
    assign w_pause = r_rd_valid && (r_byte_cnt == 2'd2);
    assign w_wr_en = (r_state == CAPTURE) && bus.cam_valid && !r_wr_done && !bus.clear;
    assign w_rd_en = (r_state == CONVERT) && !w_pause && (r_rd_ptr != PTR_END) && !bus.clear;

    assign w_sum = 16'd77  * {8'd0, r_red}
                 + 16'd150 * {8'd0, r_grn}
                 + 16'd29  * {8'd0, r_rd_data};

    // ---------------- controller ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_camera_enable <= 1'b0;
            r_rwm2_enable   <= 1'b0;
            r_rw_2          <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state         <= CAPTURE;
                        r_camera_enable <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (r_wr_done) begin
                        r_state         <= CONVERT;
                        r_camera_enable <= 1'b0;
                        r_rwm2_enable   <= 1'b1;
                        r_rw_2          <= 1'b1;
                    end
                end
                CONVERT: begin
                    if (w_leave_convert) begin
                        r_state <= READOUT;
                        r_rw_2  <= 1'b0;
                    end
                end
                READOUT: begin
                    if (bus.rwm2_done) begin
                        r_state       <= IDLE;
                        r_rwm2_enable <= 1'b0;
                        r_frame_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ---------------- capture RAM storage ----------------
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= bus.cam_data;
        if (w_rd_en) r_rd_data <= r_mem[r_rd_ptr];
    end

    // ---------------- capture RAM pointers ----------------
    // Pointers also rewind on a new frame so every start captures afresh.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_done  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else if (bus.clear || w_new_frame) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_done  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_wr_ptr == PTR_LAST) r_wr_done <= 1'b1;
            end
            r_rd_valid <= w_rd_en;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // ---------------- grayscaler ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt <= 2'd0;
            r_red      <= 8'd0;
            r_grn      <= 8'd0;
            r_gs_data  <= 8'd0;
            r_gs_valid <= 1'b0;
            r_gs_cnt   <= '0;
            r_gs_done  <= 1'b0;
        end else begin
            r_gs_valid <= 1'b0;
            if (w_leave_convert || w_new_frame) begin
                r_byte_cnt <= 2'd0;
                r_gs_cnt   <= '0;
                r_gs_done  <= 1'b0;
            end else if (r_rd_valid) begin
                case (r_byte_cnt)
                    2'd0: begin
                        r_red      <= r_rd_data;
                        r_byte_cnt <= 2'd1;
                    end
                    2'd1: begin
                        r_grn      <= r_rd_data;
                        r_byte_cnt <= 2'd2;
                    end
                    default: begin
                        r_gs_data  <= w_sum[15:8];
                        r_gs_valid <= 1'b1;
                        r_byte_cnt <= 2'd0;
                        r_gs_cnt   <= r_gs_cnt + 1'b1;
                        if (r_gs_cnt == PIX_LAST) r_gs_done <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.camera_enable = r_camera_enable;
    assign bus.gs_data       = r_gs_data;
    assign bus.gs_valid      = r_gs_valid;
    assign bus.rwm2_enable   = r_rwm2_enable;
    assign bus.rw_2          = r_rw_2;
    assign bus.frame_done    = r_frame_done;
endmodule

// File: tb/tb_capture_gray_frontend.sv
module tb_capture_gray_frontend;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    logic [7:0] gs_q [$];
    int         gs_t [$];
    logic [7:0] fr [192];

    capture_gray_frontend_if bif ();

    capture_gray_frontend #(.PIXELS(64)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every gray pixel with the cycle it appeared in.
    always @(negedge clk) begin
        if (rst_n && bif.gs_valid) begin
            gs_q.push_back(bif.gs_data);
            gs_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int gray(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b) >> 8;
    endfunction

    task automatic feed(input logic [7:0] b);
        bif.cam_valid = 1'b1;
        bif.cam_data  = b;
        tick();
        bif.cam_valid = 1'b0;
    endtask

    task automatic wait_gs(input int n, input string tag);
        int k;
        k = 0;
        while (gs_q.size() < n && k < 600) begin
            tick();
            k++;
        end
        chk(tag, 32'(gs_q.size() >= n), 32'd1);
    endtask

    task automatic pulse_start();
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        bif.rwm2_done = 1'b1;
        tick();
        bif.rwm2_done = 1'b0;
        chk({tag, "_rw2_read"}, 32'(bif.rw_2), 32'd0);
        chk({tag, "_en_readout"}, 32'(bif.rwm2_enable), 32'd1);
        chk({tag, "_fd_early"}, 32'(bif.frame_done), 32'd0);
        tick();
        tick();
        bif.rwm2_done = 1'b1;
        tick();
        bif.rwm2_done = 1'b0;
        chk({tag, "_frame_done"}, 32'(bif.frame_done), 32'd1);
        chk({tag, "_en_off"}, 32'(bif.rwm2_enable), 32'd0);
        tick();
        chk({tag, "_fd_pulse"}, 32'(bif.frame_done), 32'd0);
        chk({tag, "_cam_idle"}, 32'(bif.camera_enable), 32'd0);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_count"}, 32'(gs_q.size()), 32'd64);
        for (int i = 0; i < 64 && i < gs_q.size(); i++)
            chk($sformatf("%s_px%0d", tag, i), 32'(gs_q[i]),
                32'(gray(fr[3*i], fr[3*i+1], fr[3*i+2])));
    endtask

    initial begin
        int min_gap;
        bif.start     = 1'b0;
        bif.clear     = 1'b0;
        bif.cam_valid = 1'b0;
        bif.cam_data  = 8'd0;
        bif.rwm2_done = 1'b0;

        // frame 1: corner pixels first, then a scrambled pattern
        fr[0]  = 8'd255; fr[1]  = 8'd255; fr[2]  = 8'd255;
        fr[3]  = 8'd0;   fr[4]  = 8'd0;   fr[5]  = 8'd0;
        fr[6]  = 8'd255; fr[7]  = 8'd0;   fr[8]  = 8'd0;
        fr[9]  = 8'd0;   fr[10] = 8'd255; fr[11] = 8'd0;
        fr[12] = 8'd0;   fr[13] = 8'd0;   fr[14] = 8'd255;
        for (int i = 5; i < 64; i++) begin
            fr[3*i]   = 8'(i * 37);
            fr[3*i+1] = 8'(i * 91 + 13);
            fr[3*i+2] = 8'(255 - i * 11);
        end

        // reset state
        tick();
        chk("rst_cam_en", 32'(bif.camera_enable), 32'd0);
        chk("rst_rwm2_en", 32'(bif.rwm2_enable), 32'd0);
        chk("rst_gs_valid", 32'(bif.gs_valid), 32'd0);
        chk("rst_frame_done", 32'(bif.frame_done), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // capture with a mid-capture clear
        pulse_start();
        chk("start_cam_en", 32'(bif.camera_enable), 32'd1);
        repeat (10) feed(8'hAA);
        bif.clear     = 1'b1;
        bif.cam_valid = 1'b1;
        bif.cam_data  = 8'h55;
        tick();
        bif.clear     = 1'b0;
        bif.cam_valid = 1'b0;
        for (int i = 0; i < 192; i++) begin
            if (i % 7 == 3) tick();
            if (i == 100) begin
                pulse_start();
                chk("start_ign_capture", 32'(bif.camera_enable), 32'd1);
            end
            if (i == 191) chk("cam_en_before_last", 32'(bif.camera_enable), 32'd1);
            feed(fr[i]);
        end
        tick();
        tick();
        chk("cam_en_dropped", 32'(bif.camera_enable), 32'd0);
        chk("convert_en", 32'(bif.rwm2_enable), 32'd1);
        chk("convert_rw2", 32'(bif.rw_2), 32'd1);

        // early rwm2_done and start during CONVERT are ignored
        wait_gs(10, "gs_first10");
        bif.rwm2_done = 1'b1;
        bif.start     = 1'b1;
        tick();
        bif.rwm2_done = 1'b0;
        bif.start     = 1'b0;
        tick();
        chk("early_done_ign", 32'(bif.rw_2), 32'd1);
        chk("start_ign_convert", 32'(bif.camera_enable), 32'd0);

        wait_gs(64, "gs_all64");
        tick();
        tick();
        finish_frame("f1");
        check_frame("f1");
        if (gs_q.size() >= 5) begin
            chk("gray_white", 32'(gs_q[0]), 32'd255);
            chk("gray_black", 32'(gs_q[1]), 32'd0);
            chk("gray_red",   32'(gs_q[2]), 32'd76);
            chk("gray_green", 32'(gs_q[3]), 32'd149);
            chk("gray_blue",  32'(gs_q[4]), 32'd28);
        end
        min_gap = 1000;
        for (int i = 1; i < gs_t.size(); i++)
            if (gs_t[i] - gs_t[i-1] < min_gap) min_gap = gs_t[i] - gs_t[i-1];
        chk("gs_spacing_ge4", 32'(min_gap >= 4), 32'd1);

        // frame 2: a fresh start from IDLE runs a whole new frame
        gs_q.delete();
        gs_t.delete();
        for (int i = 0; i < 64; i++) begin
            fr[3*i]   = 8'(i * 4);
            fr[3*i+1] = 8'(255 - i * 4);
            fr[3*i+2] = 8'(i * 2);
        end
        pulse_start();
        chk("f2_cam_en", 32'(bif.camera_enable), 32'd1);
        for (int i = 0; i < 192; i++) feed(fr[i]);
        tick();
        tick();
        chk("f2_convert_en", 32'(bif.rwm2_enable), 32'd1);
        wait_gs(64, "f2_gs_all64");
        tick();
        finish_frame("f2");
        check_frame("f2");

        // frame 3: asynchronous reset in the middle of CONVERT
        gs_q.delete();
        gs_t.delete();
        pulse_start();
        for (int i = 0; i < 192; i++) feed(8'(i));
        wait_gs(5, "f3_gs_some");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cam_en", 32'(bif.camera_enable), 32'd0);
        chk("arst_rwm2_en", 32'(bif.rwm2_enable), 32'd0);
        chk("arst_rw2", 32'(bif.rw_2), 32'd0);
        chk("arst_gs_valid", 32'(bif.gs_valid), 32'd0);
        chk("arst_gs_data", 32'(bif.gs_data), 32'd0);
        chk("arst_frame_done", 32'(bif.frame_done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_cam_en", 32'(bif.camera_enable), 32'd0);
        chk("post_rst_rwm2_en", 32'(bif.rwm2_enable), 32'd0);
        pulse_start();
        chk("post_rst_start", 32'(bif.camera_enable), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/capture_gray_frontend.md
Name: capture_gray_frontend

Overview:
- Front end of each camera channel: frame capture, RGB-to-grayscale conversion, sequencing of the downstream grayscale frame memory.
- Internally three sub-blocks: a sequencing controller, a byte-wide frame buffer (capture RAM) and a grayscaler.
- A `start` pulse captures one RGB frame from the camera into the capture RAM. The block then replays it through the grayscaler into the external grayscale memory, and finally commands that memory to read out.

Parameters:
- PIXELS, 64, pixels per frame.
- DEPTH, 3*PIXELS, capture RAM depth in bytes (R,G,B per pixel).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start request.
- clear  in  1  synchronous clear of capture RAM pointers and done flag.
- cam_valid  in  1  camera byte valid.
- cam_data  in  8  camera byte stream; byte order R,G,B per pixel.
- rwm2_done  in  1  one-cycle pulse from grayscale memory: current write or read operation complete.
- camera_enable  out  1  camera streaming enable.
- gs_data  out  8  grayscale pixel.
- gs_valid  out  1  gs_data valid (one-cycle pulse per pixel).
- rwm2_enable  out  1  grayscale memory enable.
- rw_2  out  1  grayscale memory direction: 1 = write, 0 = read.
- frame_done  out  1  one-cycle pulse at end of readout.

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE. All outputs 0. Capture RAM pointers 0. Grayscaler byte counter 0. RAM contents undefined.

Controller FSM states:
- IDLE: all enables 0. `start`=1 -> CAPTURE. `start` is ignored in every other state.
- CAPTURE: camera_enable=1; capture RAM in write mode. Exit when capture done -> CONVERT.
- CONVERT: capture RAM in read mode; grayscaler enabled; rwm2_enable=1, rw_2=1. Exit on rwm2_done -> READOUT. rwm2_done is honoured only after all PIXELS gray outputs are issued (gs_done internal flag); an earlier pulse is ignored.
- READOUT: rwm2_enable=1, rw_2=0. Exit on rwm2_done -> IDLE with frame_done=1 for that one cycle.

Capture RAM:
- Write mode: on each cycle with cam_valid=1, stores cam_data at write pointer, then increments it.
- Capture done is raised on the cycle after the DEPTH-th write; the write pointer stops there and extra bytes are dropped.
- Read mode: emits one byte per cycle in address order (registered, one-cycle latency), with internal valid, except while internal pause=1. Pause holds the read pointer and suppresses valid, so no byte is lost or repeated.
- Read done after DEPTH bytes emitted.
- clear=1: read and write pointers and done flags return to 0 next cycle; contents are kept. clear takes priority over a same-cycle write or read.

Grayscaler:
- Collects 3 valid bytes R,G,B.
- On the third byte, pause=1 for exactly one cycle.
- gs_data = (77*R + 150*G + 29*B) >> 8, computed in 16-bit unsigned; result 0..255, no saturation needed.
- gs_valid pulses one cycle after the B byte.
- Throughput: at most 1 pixel per 4 cycles.
- gs_done set after PIXELS outputs; cleared on leaving CONVERT.

Other rules:
- Reset mid-frame: immediate return to IDLE. The next `start` captures a fresh frame.
- cam_valid outside CAPTURE is ignored.

Test Plan:
- Reset values: assert rst_n=0 mid-CONVERT -> all outputs 0 immediately; after release, FSM idle and camera_enable=0.
- Capture: start pulse -> camera_enable=1 the next cycle. Feed 192 bytes with cam_valid, including bubbles (cam_valid=0 cycles) -> camera_enable drops after the 192nd valid byte and FSM enters CONVERT (rwm2_enable=1, rw_2=1).
- Grayscale arithmetic: pixels (255,255,255) -> 255; (0,0,0) -> 0; (255,0,0) -> 76; (0,255,0) -> 149; (0,0,255) -> 28. Exactly 64 gs_valid pulses, in input order, spaced at least 4 cycles apart.
- Handshake: rwm2_done pulsed before the 64th gs_valid -> ignored. Pulse after it -> rw_2=0 next cycle. Second pulse -> frame_done one-cycle pulse, then IDLE.
- Start ignored: start pulses during CAPTURE/CONVERT -> no state change. A second start from IDLE runs a complete new frame.
- Clear: clear asserted mid-CAPTURE after 10 bytes -> write pointer restarts; 192 further valid bytes are needed before CONVERT.
